ti_share_refresh_reg: RTL and testbench
=======================================

// Module: ti_share_refresh_reg
// PURPOSE
//   Register stage directly downstream of the TI S-box coordinate-function bank.
//   It captures the NSHARE x WIDTH output share bits and optionally remasks them with fresh randomness.
//   It holds them in a 2-entry skid buffer with valid/ready handshakes, and is the glitch barrier
//   between TI rounds. No combinational path exists from in_shares to out_shares.
// PARAMETERS
//   NSHARE   3  number of shares per nibble (>=2)
//   WIDTH    4  bits per share (S-box width)
//   REFRESH  1  1: remask at capture using rnd; 0: pass shares unchanged, rnd ignored
// PORTS
//   clk         in   1                 rising-edge clock
//   rst         in   1                 synchronous, active-high reset
//   in_shares   in   NSHARE*WIDTH      coordinate-function outputs; share i = bits [i*WIDTH +: WIDTH]
//   in_valid    in   1                 in_shares valid
//   in_ready    out  1                 stage can accept
//   rnd         in   (NSHARE-1)*WIDTH  fresh random nibbles; r_j = bits [j*WIDTH +: WIDTH]
//   rnd_valid   in   1                 rnd valid
//   rnd_ack     out  1                 rnd consumed this cycle
//   out_shares  out  NSHARE*WIDTH      head-entry shares, driven directly from flops
//   out_valid   out  1                 head entry valid
//   out_ready   in   1                 downstream accepts head
//   occupancy   out  2                 entries held (0..2)
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge): count=0 and both entries cleared to 0.
//     out_valid=0, out_shares=0, occupancy=0, rnd_ack=0. Reset overrides all in-flight traffic.
//     Entries held at reset are discarded.
//   - rnd_ok = (REFRESH==0) | rnd_valid.
//   - in_ready = (count<2) & rnd_ok. This is combinational on count and rnd_valid only.
//     in_ready does not depend on out_ready, so a full buffer never passes through.
//   - accept = in_valid & in_ready. pop = out_valid & out_ready.
//   - rnd_ack = accept & (REFRESH==1). Each random nibble set is used exactly once, never reused.
//   - Remask on accept, REFRESH=1:
//       s'_i = s_i ^ r_i for i < NSHARE-1
//       s'_{NSHARE-1} = s_{NSHARE-1} ^ XOR(all r_j)
//     Invariant: XOR of the output shares equals XOR of the input shares.
//   - Storage is FIFO order: head entry H, tail entry T.
//       count 0, accept        -> H <= s', count 1
//       count 1, accept & pop  -> H <= s', count 1
//       count 1, accept only   -> T <= s', count 2
//       count 1, pop only      -> count 0
//       count 2, pop           -> H <= T, count 1 (no accept possible since in_ready=0)
//   - out_valid = (count!=0). out_shares = H. occupancy = count.
//   - Latency: accept at edge k gives out_valid=1 after edge k. Throughput is 1 nibble/cycle
//     when out_ready is held high.
//   - While out_valid=1 and out_ready=0, out_shares holds stable.
//   - rnd_valid=0 with REFRESH=1: in_ready=0 and the stage stalls. Held entries still drain.
//   - Unused entry contents are don't-care but must not toggle out_shares.
// TESTING
//   Configuration for all cases: NSHARE=3, WIDTH=4, REFRESH=1.
//   1. Refresh values.
//      Stimulus: in_shares=12'hA53, rnd=8'h12, rnd_valid=1, in_valid=1 for 1 cycle, out_ready=1.
//      Required: next cycle out_valid=1, out_shares=12'h941, rnd_ack was 1 at the accept.
//   2. Full buffer.
//      Stimulus: out_ready=0, push 3 values back-to-back.
//      Required: accepts 2, occupancy=2, in_ready=0. Third is accepted only after a pop.
//      Output order matches input order.
//   3. Randomness starvation.
//      Stimulus: rnd_valid=0, in_valid=1.
//      Required: in_ready=0, rnd_ack=0, buffer unchanged. rnd_valid=1 then accepts the next cycle.
//   4. Streaming.
//      Stimulus: 256 random in_shares and rnd, valid=ready=1.
//      Required: 1 output per cycle after 1-cycle latency. XOR of output shares equals
//      XOR of input shares for every item.
//   5. Reset mid-operation.
//      Stimulus: occupancy=2, assert rst for 1 cycle.
//      Required: next cycle out_valid=0, occupancy=0, out_shares=0. No stale entry emerges.
//   6. REFRESH=0.
//      Stimulus: in_shares=12'hA53, rnd_valid=0.
//      Required: accepted, out_shares=12'hA53, rnd_ack stays 0.

Source files
------------

// File: rtl/ti_share_refresh_reg_if.sv
// Handshake bundle for the TI share refresh register: upstream shares, fresh
// randomness, and the downstream head entry with its occupancy.
interface ti_share_refresh_reg_if #(
  parameter int NSHARE = 3,
  parameter int WIDTH  = 4
);
  logic [NSHARE*WIDTH-1:0]     in_shares;
  logic                        in_valid;
  logic                        in_ready;
  logic [(NSHARE-1)*WIDTH-1:0] rnd;
  logic                        rnd_valid;
  logic                        rnd_ack;
  logic [NSHARE*WIDTH-1:0]     out_shares;
  logic                        out_valid;
  logic                        out_ready;
  logic [1:0]                  occupancy;

  // master drives the stage (producer plus consumer side), slave is the stage
  modport master (
    output in_shares, in_valid, rnd, rnd_valid, out_ready,
    input  in_ready, rnd_ack, out_shares, out_valid, occupancy
  );

  modport slave (
    input  in_shares, in_valid, rnd, rnd_valid, out_ready,
    output in_ready, rnd_ack, out_shares, out_valid, occupancy
  );
endinterface

// File: rtl/ti_share_refresh_reg.sv
// Glitch-barrier register after the TI S-box bank: optional remask on capture,
// 2-entry skid buffer, outputs driven straight from flops.
module ti_share_refresh_reg #(
  parameter int NSHARE  = 3,
  parameter int WIDTH   = 4,
  parameter int REFRESH = 1
) (
  input logic                   clk,
  input logic                   rst,
  ti_share_refresh_reg_if.slave bus
);

  localparam int DW = NSHARE * WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fill_e;

  fill_e         state, state_next;
  logic [DW-1:0] head, tail;
  logic [DW-1:0] masked;
  logic          rnd_ok, accept, pop;
  logic          load_head, load_tail, move_tail;

  // Remask keeps the XOR of all shares unchanged: every r_j is applied twice.
  generate
    if (REFRESH != 0) begin : g_refresh
      logic [WIDTH-1:0] rnd_sum;

      always_comb begin
        rnd_sum = '0;
        for (int j = 0; j < NSHARE - 1; j++)
          rnd_sum ^= bus.rnd[j*WIDTH +: WIDTH];
      end

      always_comb begin
        masked = bus.in_shares;
        for (int i = 0; i < NSHARE - 1; i++)
          masked[i*WIDTH +: WIDTH] = bus.in_shares[i*WIDTH +: WIDTH] ^ bus.rnd[i*WIDTH +: WIDTH];
        masked[(NSHARE-1)*WIDTH +: WIDTH] = bus.in_shares[(NSHARE-1)*WIDTH +: WIDTH] ^ rnd_sum;
      end

      assign rnd_ok = bus.rnd_valid;
    end else begin : g_pass
      assign masked = bus.in_shares;
      assign rnd_ok = 1'b1;
    end
  endgenerate

  // in_ready never looks at out_ready, so a full buffer cannot pass data through.
  assign bus.in_ready = (state != FULL) && rnd_ok;
  assign accept       = bus.in_valid && bus.in_ready;
  assign pop          = bus.out_valid && bus.out_ready;
  assign bus.rnd_ack  = accept && (REFRESH != 0);

  assign bus.out_valid  = (state != EMPTY);
  assign bus.out_shares = head;
  assign bus.occupancy  = state;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_next = state;
    load_head  = 1'b0;
    load_tail  = 1'b0;
    move_tail  = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        load_head  = 1'b1;
        state_next = ONE;
      end
      ONE: begin
        if (accept && pop) begin
          load_head = 1'b1;
        end else if (accept) begin
          load_tail  = 1'b1;
          state_next = FULL;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: if (pop) begin
        move_tail  = 1'b1;
        state_next = ONE;
      end
      default: state_next = EMPTY;
    endcase
  end

  // Only head feeds out_shares; tail may change freely without glitching the output.
  always_ff @(posedge clk) begin
    // NOTE: entries are cleared on reset so out_shares reads 0 and no stale share survives.
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (load_head)      head <= masked;
      else if (move_tail) head <= tail;
      if (load_tail)      tail <= masked;
    end
  end

endmodule

// File: tb/tb_ti_share_refresh_reg.sv
// Scoreboard bench for ti_share_refresh_reg: driver pushes expected remasked
// entries, a separate monitor pops and compares on every downstream transfer.
module tb_ti_share_refresh_reg;

  localparam int NSHARE = 3;
  localparam int WIDTH  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ti_share_refresh_reg_if #(.NSHARE(NSHARE), .WIDTH(WIDTH)) bus ();
  ti_share_refresh_reg_if #(.NSHARE(NSHARE), .WIDTH(WIDTH)) bus0 ();

  ti_share_refresh_reg #(.NSHARE(NSHARE), .WIDTH(WIDTH), .REFRESH(1)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  ti_share_refresh_reg #(.NSHARE(NSHARE), .WIDTH(WIDTH), .REFRESH(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  logic [11:0] sb_q[$];
  logic [3:0]  xor_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference remask: share i picks up r_i, the last share picks up the XOR of all r.
  function automatic logic [11:0] remask(input logic [11:0] sh, input logic [7:0] r);
    logic [3:0] s[3];
    logic [3:0] rr[2];
    for (int i = 0; i < 3; i++) s[i] = sh[i*4 +: 4];
    rr[0] = r[3:0];
    rr[1] = r[7:4];
    return {s[2] ^ rr[0] ^ rr[1], s[1] ^ rr[1], s[0] ^ rr[0]};
  endfunction

  function automatic logic [3:0] share_xor(input logic [11:0] sh);
    return sh[3:0] ^ sh[7:4] ^ sh[11:8];
  endfunction

  // Monitor: a transfer happens at the next rising edge whenever valid & ready.
  initial begin
    logic [11:0] exp_sh;
    logic [3:0]  exp_x;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got %0h, expected no output", bus.out_shares);
        end else begin
          exp_sh = sb_q.pop_front();
          exp_x  = xor_q.pop_front();
          check("out_shares", bus.out_shares, exp_sh);
          check("xor_invariant", share_xor(bus.out_shares), exp_x);
          pops++;
        end
      end
    end
  end

  // One clock of stimulus; called and returns on a falling edge.
  task automatic cycle(input logic iv, input logic [11:0] sh, input logic rv,
                       input logic [7:0] r, input logic ordy, output logic acc);
    logic exp_rdy;
    bus.in_valid  = iv;
    bus.in_shares = sh;
    bus.rnd_valid = rv;
    bus.rnd       = r;
    bus.out_ready = ordy;
    #1;
    exp_rdy = (sb_q.size() < 2) && rv;
    check("in_ready", bus.in_ready, exp_rdy);
    check("rnd_ack", bus.rnd_ack, iv && exp_rdy);
    check("occupancy", bus.occupancy, sb_q.size());
    check("out_valid", bus.out_valid, sb_q.size() != 0);
    if (sb_q.size() != 0) check("head_shares", bus.out_shares, sb_q[0]);
    acc = iv && exp_rdy;
    if (acc) begin
      sb_q.push_back(remask(sh, r));
      xor_q.push_back(share_xor(sh));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    xor_q.delete();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_occupancy", bus.occupancy, 0);
    check("rst_out_shares", bus.out_shares, 0);
    check("rst_rnd_ack", bus.rnd_ack, 0);
    check("rst0_out_valid", bus0.out_valid, 0);
  endtask

  initial begin
    logic acc;
    int   p0;
    rst = 1'b1;
    bus.in_shares = '0;  bus.in_valid = 1'b0;  bus.rnd = '0;  bus.rnd_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus0.in_shares = '0; bus0.in_valid = 1'b0; bus0.rnd = '0; bus0.rnd_valid = 1'b0;
    bus0.out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Refresh values
    cycle(1'b1, 12'hA53, 1'b1, 8'h12, 1'b1, acc);
    check("t1_accept", acc, 1);
    check("t1_out_valid", bus.out_valid, 1);
    check("t1_out_shares", bus.out_shares, 12'h941);
    cycle(1'b0, 12'h000, 1'b1, 8'h00, 1'b1, acc);

    // Full buffer: third push waits for a pop, order preserved
    cycle(1'b1, 12'h111, 1'b1, 8'h34, 1'b0, acc);
    cycle(1'b1, 12'h222, 1'b1, 8'h56, 1'b0, acc);
    check("t2_occupancy", bus.occupancy, 2);
    cycle(1'b1, 12'h333, 1'b1, 8'h78, 1'b0, acc);
    check("t2_third_blocked", acc, 0);
    cycle(1'b1, 12'h333, 1'b1, 8'h78, 1'b1, acc);
    cycle(1'b1, 12'h333, 1'b1, 8'h78, 1'b0, acc);
    check("t2_third_after_pop", acc, 1);
    repeat (3) cycle(1'b0, 12'h000, 1'b1, 8'h00, 1'b1, acc);

    // Randomness starvation
    cycle(1'b1, 12'h444, 1'b1, 8'h9A, 1'b0, acc);
    repeat (3) cycle(1'b1, 12'h555, 1'b0, 8'hBC, 1'b0, acc);
    check("t3_buffer_unchanged", bus.occupancy, 1);
    cycle(1'b1, 12'h555, 1'b1, 8'hBC, 1'b0, acc);
    check("t3_accept_after_rnd", acc, 1);
    repeat (3) cycle(1'b0, 12'h000, 1'b1, 8'h00, 1'b1, acc);

    // Streaming: one transfer per cycle
    p0 = pops;
    for (int i = 0; i < 256; i++)
      cycle(1'b1, 12'($urandom), 1'b1, 8'($urandom), 1'b1, acc);
    cycle(1'b0, 12'h000, 1'b1, 8'h00, 1'b1, acc);
    check("t4_stream_pops", pops - p0, 256);

    // Random handshakes
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom), 12'($urandom), ($urandom_range(3, 0) != 0),
            8'($urandom), 1'($urandom), acc);
    repeat (3) cycle(1'b0, 12'h000, 1'b1, 8'h00, 1'b1, acc);

    // Reset mid-operation with a full buffer
    cycle(1'b1, 12'hDEF, 1'b1, 8'h55, 1'b0, acc);
    cycle(1'b1, 12'hFED, 1'b1, 8'hAA, 1'b0, acc);
    check("t5_full", bus.occupancy, 2);
    do_reset();
    repeat (3) cycle(1'b0, 12'h000, 1'b1, 8'h00, 1'b1, acc);

    // REFRESH=0 instance passes shares unchanged and ignores rnd
    bus0.in_shares = 12'hA53;
    bus0.rnd       = 8'hFF;
    bus0.rnd_valid = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.out_ready = 1'b0;
    #1;
    check("t6_in_ready", bus0.in_ready, 1);
    check("t6_rnd_ack", bus0.rnd_ack, 0);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    #1;
    check("t6_out_valid", bus0.out_valid, 1);
    check("t6_out_shares", bus0.out_shares, 12'hA53);
    check("t6_occupancy", bus0.occupancy, 1);
    check("t6_rnd_ack_idle", bus0.rnd_ack, 0);
    bus0.out_ready = 1'b1;
    @(negedge clk);
    check("t6_drained", bus0.out_valid, 0);
    bus0.out_ready = 1'b0;

    check("final_occupancy", bus.occupancy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
